data_port_arbiter: RTL and testbench
====================================

Name: data_port_arbiter

Overview:
- Shares the single Bridge data port between two masters: M0 (CPU memory stage) and M1 (DMA / debug copy engine).
- Grants one master per cycle and drives the Bridge request fields.
- Sequences the Bridge's two-cycle read (address cycle, then registered-data cycle), routes read data and exception codes back to the owner, and bounds M1 starvation with a wait counter.

Parameters:
MAX_WAIT, 4, consecutive cycles M1 may be denied while requesting before it is forced to win (1..15)
SEL_IDLE, 3'b000, data_sel encoding meaning "no memory operation"

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
m0_req  in  1  M0 access request
m0_addr  in  32  M0 byte address
m0_wdata  in  32  M0 store data
m0_we  in  1  M0 store (1) / load (0)
m0_sel  in  3  M0 width select (same encoding as Bridge data_sel)
m0_gnt  out  1  M0 request accepted this cycle
m0_exc  out  5  Bridge exception code for M0's granted access, else 0
m0_rvalid  out  1  M0 load data valid
m0_rdata  out  32  M0 load data
m1_req, m1_addr, m1_wdata, m1_we, m1_sel, m1_gnt, m1_exc, m1_rvalid, m1_rdata: same as M0 for M1
data_addr  out  32  to Bridge
data_wdata  out  32  to Bridge
data_mem_write  out  1  to Bridge
data_sel  out  3  to Bridge
data_req  out  1  to Bridge write-block input; 1 suppresses the store
data_rdata  in  32  from Bridge
data_exc  in  5  from Bridge (combinational on current request)

Behaviour:
- Reset (async, rst=1): state=IDLE, wait_cnt=0, owner=NONE. All gnt/rvalid=0, rdata=0, exc=0. data_sel=SEL_IDLE, data_mem_write=0, data_req=1, data_addr=data_wdata=0.
- FSM states: IDLE (accept new access) and RDATA (data cycle of a read).
- Arbitration in IDLE:
  - Winner = M1 if m1_req && (!m0_req || wait_cnt==MAX_WAIT); else M0 if m0_req; else none.
  - Grant is combinational in the same cycle. Winner's addr/wdata/we/sel drive the Bridge.
  - No winner: data_sel=SEL_IDLE, data_mem_write=0, data_req=1.
- Exceptions:
  - data_exc is routed combinationally to the winner's mN_exc; the loser's exc=0.
  - Nonzero data_exc on a store forces data_req=1, so no write occurs. Grant is still given (access completes with exception).
  - Exception on a load: grant given, no transition to RDATA, no rvalid.
- Store: single cycle; data_req=0 when granted with no exception. Stay in IDLE.
- Load (we=0, sel!=SEL_IDLE, no exc): registers owner, addr, sel; next state RDATA.
- In RDATA:
  - Re-presents the latched addr/sel with data_mem_write=0 and data_req=1, so Bridge sign/zero extension uses the correct address.
  - Both gnt=0 (all requests stall one cycle).
  - Owner's rvalid=1 and rdata=data_rdata; the other master's rdata=0.
  - Returns to IDLE unconditionally.
- rvalid is a combinational decode of (state==RDATA, owner); rdata is 0 whenever rvalid=0.
- wait_cnt (4-bit):
  - Increments each cycle m1_req=1 && m1_gnt=0, including RDATA cycles; saturates at MAX_WAIT.
  - Clears when m1_gnt=1 or m1_req=0.
- Simultaneous requests with wait_cnt<MAX_WAIT: M0 wins.
- Back-to-back loads: minimum 2 cycles each; a load's RDATA cycle blocks any grant.
- Reset mid-RDATA: pending response is dropped with no rvalid; FSM and bus return to IDLE immediately.

Test Plan:
- M0 lw 0x0000_0100 (DM holds 0x1234_5678), M1 idle -> cycle0 m0_gnt=1; cycle1 data_addr=0x100, data_req=1, m0_rvalid=1, m0_rdata=0x1234_5678, both gnt=0.
- Both masters issue continuous sw, MAX_WAIT=4 -> M0 granted cycles 0-3, M1 granted cycle 4 with wait_cnt cleared, M0 granted again cycle 5.
- M1 sw to 0x0000_7f08 -> m1_gnt=1, m1_exc=5 (AdES), data_req=1 (no TC0 write), m0_exc=0, state stays IDLE.
- M0 lw 0x0000_3000 (unmapped) -> m0_exc=4 (AdEL), m0_gnt=1, no RDATA cycle, m0_rvalid never asserts.
- M0 lw issued, M1 requests during the RDATA cycle -> m1_gnt=0 in RDATA, m1_gnt=1 the following cycle.
- Assert rst during RDATA -> same instant m0_rvalid=0, data_sel=SEL_IDLE, data_req=1; after release, first request granted normally.

Source files
------------

// File: rtl/data_port_arbiter.sv
// data_port_arbiter
// Shares the single Bridge data port between two masters:
//   M0 - CPU memory stage, normally preferred
//   M1 - DMA / debug copy engine, protected from starvation by a wait counter
// Loads take two cycles on the Bridge: the address cycle, which carries the
// grant, and the registered-data cycle (RDATA), where every grant is held off.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mN_req/addr/wdata/we/sel master N access request fields (N = 0, 1)
//   mN_gnt                   master N request accepted this cycle
//   mN_exc                   Bridge exception code for master N's granted access
//   mN_rvalid, mN_rdata      master N load data return
//   data_addr/wdata/mem_write/sel/req  request fields driven to the Bridge
//   data_rdata, data_exc     Bridge read data and exception code
module data_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter logic [2:0]  SEL_IDLE = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [2:0]  m0_sel,
    output logic        m0_gnt,
    output logic [4:0]  m0_exc,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [2:0]  m1_sel,
    output logic        m1_gnt,
    output logic [4:0]  m1_exc,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic        data_mem_write,
    output logic [2:0]  data_sel,
    output logic        data_req,
    input  logic [31:0] data_rdata,
    input  logic [4:0]  data_exc
);

    typedef enum logic {IDLE, RDATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t      state;
    owner_t      owner;
    logic [31:0] lat_addr;
    logic [2:0]  lat_sel;
    logic [3:0]  wait_cnt;

    logic win_m0;
    logic win_m1;
    logic exc_hit;
    logic load_start;

    // Arbitration only happens in IDLE. M1 wins when M0 is quiet or when it
    // has been denied for MAX_WAIT cycles in a row; otherwise M0 wins. Reset
    // is folded in so no grant can leak out while rst is held.
    always_comb begin
        win_m1 = (state == IDLE) && !rst && m1_req && (!m0_req || (wait_cnt == WAIT_LIMIT));
        win_m0 = (state == IDLE) && !rst && m0_req && !win_m1;
    end

    assign exc_hit = (data_exc != 5'd0);

    // A load that the Bridge accepted without exception needs a data cycle.
    // A store or a faulting access completes in its grant cycle.
    always_comb begin
        load_start = 1'b0;
        if (win_m0) begin
            load_start = !m0_we && (m0_sel != SEL_IDLE) && !exc_hit;
        end else if (win_m1) begin
            load_start = !m1_we && (m1_sel != SEL_IDLE) && !exc_hit;
        end
    end

    // Bridge request mux. In RDATA the latched load address and width are
    // re-presented so the Bridge extends the returned data from the right
    // byte lane. data_req is active-low write enable: it only drops for a
    // granted store that raised no exception.
    always_comb begin
        data_addr      = 32'd0;
        data_wdata     = 32'd0;
        data_mem_write = 1'b0;
        data_sel       = SEL_IDLE;
        data_req       = 1'b1;
        m0_gnt         = 1'b0;
        m1_gnt         = 1'b0;
        m0_exc         = 5'd0;
        m1_exc         = 5'd0;
        if (state == RDATA) begin
            data_addr = lat_addr;
            data_sel  = lat_sel;
        end else if (win_m0) begin
            data_addr      = m0_addr;
            data_wdata     = m0_wdata;
            data_mem_write = m0_we;
            data_sel       = m0_sel;
            data_req       = !(m0_we && !exc_hit);
            m0_gnt         = 1'b1;
            m0_exc         = data_exc;
        end else if (win_m1) begin
            data_addr      = m1_addr;
            data_wdata     = m1_wdata;
            data_mem_write = m1_we;
            data_sel       = m1_sel;
            data_req       = !(m1_we && !exc_hit);
            m1_gnt         = 1'b1;
            m1_exc         = data_exc;
        end
    end

    // Read data goes only to the master that owns the outstanding load;
    // everyone else sees zero.
    always_comb begin
        m0_rvalid = (state == RDATA) && (owner == OWN_M0);
        m1_rvalid = (state == RDATA) && (owner == OWN_M1);
        m0_rdata  = m0_rvalid ? data_rdata : 32'd0;
        m1_rdata  = m1_rvalid ? data_rdata : 32'd0;
    end

    // Two-state load sequencer. RDATA always lasts exactly one cycle, so
    // back-to-back loads cost two cycles each. An asynchronous reset drops
    // any outstanding load without producing rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            lat_addr <= 32'd0;
            lat_sel  <= SEL_IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= RDATA;
                        owner    <= win_m1 ? OWN_M1 : OWN_M0;
                        lat_addr <= data_addr;
                        lat_sel  <= data_sel;
                    end
                end
                RDATA: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
                default: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Starvation counter for M1: counts every cycle M1 asks and is refused,
    // RDATA cycles included, saturating at the limit. It clears as soon as
    // M1 is served or stops asking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (m1_req && !m1_gnt) begin
            if (wait_cnt < WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_data_port_arbiter.sv
// tb_data_port_arbiter
// Directed bench for data_port_arbiter. A tiny combinational Bridge model
// supplies read data and exception codes. Each stimulus cycle that should
// make the DUT present a grant or rvalid pushes the expected response into a
// queue; an independent monitor pops and compares whenever the DUT presents.
module tb_data_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_sel, m1_sel;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [4:0]  m0_exc, m1_exc;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_mem_write, data_req;
    logic [2:0]  data_sel;
    logic [4:0]  data_exc;

    typedef struct {
        string        name;
        logic [111:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    data_port_arbiter #(.MAX_WAIT(4), .SEL_IDLE(3'b000)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_gnt(m0_gnt), .m0_exc(m0_exc), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_gnt(m1_gnt), .m1_exc(m1_exc), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_mem_write(data_mem_write),
        .data_sel(data_sel), .data_req(data_req), .data_rdata(data_rdata), .data_exc(data_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bridge stand-in: 0x7f08 rejects stores (AdES=5), 0x3000 is unmapped
    // for loads (AdEL=4). Word 0x100 holds 0x12345678; others read 0xCAFExxxx.
    always_comb begin
        data_exc = 5'd0;
        if (data_sel != 3'b000) begin
            if (data_mem_write && data_addr == 32'h0000_7f08) data_exc = 5'd5;
            if (!data_mem_write && data_addr == 32'h0000_3000) data_exc = 5'd4;
        end
        data_rdata = (data_addr == 32'h0000_0100) ? 32'h1234_5678 : (32'hCAFE_0000 | {16'd0, data_addr[15:0]});
    end

    function automatic logic [111:0] mk(input logic g0, g1, input logic [4:0] e0, e1,
                                        input logic rv0, rv1, input logic [31:0] rd0, rd1,
                                        input logic dreq, dmw, input logic [31:0] addr);
        return {g0, g1, e0, e1, rv0, rv1, rd0, rd1, dreq, dmw, addr};
    endfunction

    function automatic logic [111:0] observed();
        return {m0_gnt, m1_gnt, m0_exc, m1_exc, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                data_req, data_mem_write, data_addr};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of requests (word-sized accesses) and, when the DUT
    // should present a grant or rvalid this cycle, queues the expectation.
    task automatic applyStimulus(input logic r0, w0, input logic [31:0] a0,
                                 input logic r1, w1, input logic [31:0] a1,
                                 input string name, input bit has_exp, input logic [111:0] ev);
        exp_t e;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = a0 ^ 32'h5555_0000; m0_sel = r0 ? 3'b010 : 3'b000;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = a1 ^ 32'h3333_0000; m1_sel = r1 ? 3'b010 : 3'b000;
        if (has_exp) begin
            e.name  = name;
            e.value = ev;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every cycle where the DUT presents a grant or data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (m0_gnt || m1_gnt || m0_rvalid || m1_rvalid)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_output: got %h, expected no output", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e.value) begin
                        failures++;
                        $display("[TB] FAIL %s: got %h, expected %h", e.name, observed(), e.value);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_sel = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_sel = 0;
        #12;
        checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        checkOutput("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        checkOutput("rst_data_sel", 32'(data_sel), 32'd0);
        checkOutput("rst_data_req", 32'(data_req), 32'd1);
        checkOutput("rst_data_mem_write", 32'(data_mem_write), 32'd0);
        checkOutput("rst_data_addr", data_addr, 32'd0);
        checkOutput("rst_data_wdata", data_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] M0 load from 0x100");
        applyStimulus(1, 0, 32'h100, 0, 0, 0, "lw_grant", 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100));
        applyStimulus(0, 0, 0, 0, 0, 0, "lw_rdata", 1, mk(0, 0, 0, 0, 1, 0, 32'h1234_5678, 0, 1, 0, 32'h100));

        $display("[TB] Continuous stores from both masters");
        for (int i = 0; i < 6; i++) begin
            if (i == 4)
                applyStimulus(1, 1, 32'h200, 1, 1, 32'h400, "starve_m1_win", 1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400));
            else
                applyStimulus(1, 1, 32'h200, 1, 1, 32'h400, "starve_m0_win", 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, "", 0, '0);

        $display("[TB] M1 store to protected address");
        applyStimulus(0, 0, 0, 1, 1, 32'h7f08, "m1_ades", 1, mk(0, 1, 0, 5, 0, 0, 0, 0, 1, 1, 32'h7f08));
        applyStimulus(0, 0, 0, 1, 1, 32'h500, "after_ades", 1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h500));

        $display("[TB] M0 load from unmapped address");
        applyStimulus(1, 0, 32'h3000, 0, 0, 0, "m0_adel", 1, mk(1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 32'h3000));
        applyStimulus(0, 0, 0, 0, 0, 0, "", 0, '0);
        applyStimulus(0, 0, 0, 0, 0, 0, "", 0, '0);

        $display("[TB] M1 request during M0 data cycle");
        applyStimulus(1, 0, 32'h104, 0, 0, 0, "lw2_grant", 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h104));
        applyStimulus(0, 0, 0, 1, 1, 32'h600, "lw2_rdata_m1_stall", 1, mk(0, 0, 0, 0, 1, 0, 32'hCAFE_0104, 0, 1, 0, 32'h104));
        applyStimulus(0, 0, 0, 1, 1, 32'h600, "m1_after_rdata", 1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h600));

        $display("[TB] Reset during data cycle");
        applyStimulus(1, 0, 32'h108, 0, 0, 0, "lw3_grant", 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h108));
        m0_req = 0; m0_sel = 0; m1_req = 0; m1_sel = 0;
        #1;
        checkOutput("rdata_before_rst", 32'(m0_rvalid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_rvalid", 32'(m0_rvalid), 32'd0);
        checkOutput("rst_mid_data_sel", 32'(data_sel), 32'd0);
        checkOutput("rst_mid_data_req", 32'(data_req), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 1, 32'h700, 0, 0, 0, "post_rst_grant", 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h700));
        applyStimulus(0, 0, 0, 0, 0, 0, "", 0, '0);
        applyStimulus(0, 0, 0, 0, 0, 0, "", 0, '0);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
